dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU MEM stage and a DMA/loader port.
//  Issues one access per cycle with CPU priority by default. A starvation counter
//  bounds DMA wait, and DMA may lock the memory for bounded bursts.
//  Read data returns one cycle after grant (sync-read DMEM) and is routed to the owner.
// PARAMETERS
//  DATA_WIDTH  16   data word width
//  ADDR_W      8    DMEM address width (DMEM_DEPTH = 2**ADDR_W)
//  MAX_WAIT    4    consecutive denied DMA cycles before DMA wins one arbitration
//  LOCK_MAX    8    max DMA beats per locked burst before forced release
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           asynchronous, active-low reset (0 = reset)
//  cpu_req     in   1           CPU access request (from EX/MEM mem_read|mem_write)
//  cpu_we      in   1           1 = write, 0 = read
//  cpu_addr    in   ADDR_W      CPU address
//  cpu_wdata   in   DATA_WIDTH  CPU store data
//  cpu_gnt     out  1           CPU access issued this cycle
//  cpu_stall   out  1           cpu_req & ~cpu_gnt; drives pipeline stall
//  cpu_rvalid  out  1           CPU read data valid
//  cpu_rdata   out  DATA_WIDTH  CPU read data
//  dma_req     in   1           DMA access request
//  dma_we      in   1           1 = write, 0 = read
//  dma_addr    in   ADDR_W      DMA address
//  dma_wdata   in   DATA_WIDTH  DMA write data
//  dma_lock    in   1           hold memory after this beat (burst)
//  dma_gnt     out  1           DMA access issued this cycle
//  dma_rvalid  out  1           DMA read data valid
//  dma_rdata   out  DATA_WIDTH  DMA read data
//  mem_read    out  1           to DMEM
//  mem_write   out  1           to DMEM
//  mem_addr    out  ADDR_W      to DMEM
//  mem_wdata   out  DATA_WIDTH  to DMEM
//  mem_rdata   in   DATA_WIDTH  from DMEM, valid the cycle after mem_read
// BEHAVIOUR
//  - Grant is combinational from the requests and the registered state. At most one gnt is high per cycle.
//  - The mem_* command mirrors the winner in the same cycle. With no grant: mem_read = mem_write = 0, and addr/wdata hold 0.
//  - State ARB, default: CPU wins when both request.
//  - State ARB, starvation override: DMA wins if wait_cnt == MAX_WAIT, or if rr_cpu == 0 after a lock release.
//  - wait_cnt: +1 on each cycle with dma_req & ~dma_gnt, saturating at MAX_WAIT. Cleared on dma_gnt or when dma_req = 0.
//  - ARB -> LOCK on dma_gnt & dma_lock. beat_cnt is loaded with 1.
//  - In LOCK, DMA has absolute priority. beat_cnt increments on each dma_gnt.
//  - LOCK -> ARB when dma_gnt & ~dma_lock, or when dma_req = 0 (release, no grant).
//  - LOCK -> ARB forced when beat_cnt == LOCK_MAX at a dma_gnt. This sets cpu_first = 1.
//  - cpu_first = 1 gives the CPU priority in the next arbitration even if wait_cnt is saturated. It clears on the next cpu_gnt, or when cpu_req = 0.
//  - Read response: rd_pend <= gnt & ~we, and rd_owner <= winner, both registered.
//  - Read response next cycle: {owner}_rvalid = rd_pend & owner match; {owner}_rdata = mem_rdata; the other port's rdata = 0.
//  - Writes produce no rvalid.
//  - A write granted the same cycle as an rvalid is legal (pipelined).
//  - Reset (async, reset = 0): state = ARB, wait_cnt = 0, beat_cnt = 0, cpu_first = 0, rd_pend = 0. All rvalid/rdata = 0.
//  - Reset mid-burst or with a pending read drops the response. No rvalid is issued after release.
//  - Requesters hold req and payload stable until gnt. Changing the payload while denied is allowed; the arbiter samples only at gnt.
// STRUCTURE
//  - Package dmem_arb_pkg holds:
//      typedef arb_state_t {ARB, LOCK}
//      typedef owner_t {OWN_CPU, OWN_DMA}
//      localparam widths $clog2(MAX_WAIT+1) and $clog2(LOCK_MAX+1)
//  - Sub-module sat_counter (WIDTH, MAX; inc, clr -> cnt, at_max) is used for both wait_cnt and beat_cnt.
//  - Top level: arbitration comb, state/flag regs, response pipe reg, output muxes.
// TESTING
//  1. CPU read only: cpu_req=1, addr=0x10, DMEM[0x10]=0xBEEF -> cpu_gnt same cycle, mem_read=1; next cycle cpu_rvalid=1, cpu_rdata=0xBEEF.
//  2. Contention: both req every cycle, MAX_WAIT=4 -> CPU granted 4 cycles, DMA granted cycle 5, then CPU; cpu_stall=1 only on cycle 5.
//  3. Locked burst: DMA writes 0x20..0x2A with dma_lock=1, LOCK_MAX=8, cpu_req=1 -> 8 DMA gnts back-to-back, then cpu_gnt, then DMA resumes.
//  4. Read routing: DMA read 0x05 then CPU read 0x06 in consecutive cycles -> dma_rvalid then cpu_rvalid, each with its own data and no cross-talk.
//  5. Reset mid-lock: reset=0 during beat 3 with a read pending -> no rvalid; after release, state ARB and CPU wins the first contention.
//  6. Simultaneous write/response: CPU read at t, DMA write at t+1 -> cpu_rvalid at t+1, DMEM written at t+1 edge.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and counter sizing for the data-memory arbiter.
// Covers the ARB/LOCK state, the read-response owner and the counter width helper.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam int MAX_WAIT_DEF = 4;
    localparam int LOCK_MAX_DEF = 8;
    localparam int WAIT_W_DEF   = $clog2(MAX_WAIT_DEF + 1);
    localparam int BEAT_W_DEF   = $clog2(LOCK_MAX_DEF + 1);

    // Bits needed to hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes precedence over increment.
// Used for both the DMA starvation count and the locked-burst beat count.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max
);

    logic [WIDTH-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (inc && !at_max) begin
            cnt_r <= cnt_r + WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt    = cnt_r;
    assign at_max = (cnt_r == WIDTH'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between the CPU MEM stage and a DMA/loader port.
// CPU-first arbitration with bounded DMA starvation, bounded DMA lock bursts, and read-data routing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 8,
    parameter int MAX_WAIT   = MAX_WAIT_DEF,
    parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_W-1:0]     dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_lock,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WAIT_W = cnt_width(MAX_WAIT);
    localparam int BEAT_W = cnt_width(LOCK_MAX);

    arb_state_t  state_r;
    owner_t      rd_owner_r;
    logic        cpu_first_r;
    logic        rel_pend_r;
    logic        rd_pend_r;

    logic        cpu_gnt_s;
    logic        dma_gnt_s;
    logic        dma_pri_s;
    logic        lock_nxt_s;
    logic        forced_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        wait_max_s;
    logic        beat_last_s;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic [BEAT_W-1:0] beat_cnt_s;
    logic        cnt_unused_s;

    sat_counter #(.WIDTH(WAIT_W), .MAX(MAX_WAIT)) u_wait_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (dma_req & ~dma_gnt_s),
        .clr    (dma_gnt_s | ~dma_req),
        .cnt    (wait_cnt_s),
        .at_max (wait_max_s)
    );

    // Saturating one short of LOCK_MAX, so at_max marks the last beat the lock may take.
    sat_counter #(.WIDTH(BEAT_W), .MAX(LOCK_MAX - 1)) u_beat_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (dma_gnt_s),
        .clr    (~lock_nxt_s),
        .cnt    (beat_cnt_s),
        .at_max (beat_last_s)
    );

    assign cnt_unused_s = ^{wait_cnt_s, beat_cnt_s};

    // Arbitration: LOCK hands the memory to DMA only; ARB is CPU-first unless DMA is overdue.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dma_gnt_s = 1'b0;
        dma_pri_s = (wait_max_s | rel_pend_r) & ~cpu_first_r;
        if (state_r == LOCK) begin
            dma_gnt_s = dma_req;
        end else if (dma_req && (dma_pri_s || !cpu_req)) begin
            dma_gnt_s = 1'b1;
        end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
        end
    end

    // Burst continuation and the forced end of an over-long burst.
    always_comb begin
        lock_nxt_s  = dma_gnt_s & dma_lock & ~beat_last_s;
        forced_s    = dma_gnt_s & dma_lock & beat_last_s;
        mem_read_s  = (cpu_gnt_s & ~cpu_we) | (dma_gnt_s & ~dma_we);
        mem_write_s = (cpu_gnt_s & cpu_we) | (dma_gnt_s & dma_we);
    end

    // State, fairness flags and the one-deep read-response pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ARB;
            cpu_first_r <= 1'b0;
            rel_pend_r  <= 1'b0;
            rd_pend_r   <= 1'b0;
            rd_owner_r  <= OWN_CPU;
        end else begin
            state_r <= lock_nxt_s ? LOCK : ARB;
            if (forced_s) begin
                cpu_first_r <= 1'b1;
            end else if (cpu_gnt_s || !cpu_req) begin
                cpu_first_r <= 1'b0;
            end else begin
                cpu_first_r <= cpu_first_r;
            end
            // After the CPU's one guaranteed slot, the cut-off DMA burst gets the next arbitration.
            if (forced_s) begin
                rel_pend_r <= 1'b1;
            end else if (dma_gnt_s || !dma_req) begin
                rel_pend_r <= 1'b0;
            end else begin
                rel_pend_r <= rel_pend_r;
            end
            rd_pend_r  <= mem_read_s;
            rd_owner_r <= dma_gnt_s ? OWN_DMA : OWN_CPU;
        end
    end

    assign cpu_gnt   = cpu_gnt_s;
    assign dma_gnt   = dma_gnt_s;
    assign cpu_stall = cpu_req & ~cpu_gnt_s;
    assign mem_read  = mem_read_s;
    assign mem_write = mem_write_s;
    assign mem_addr  = dma_gnt_s ? dma_addr  : (cpu_gnt_s ? cpu_addr  : {ADDR_W{1'b0}});
    assign mem_wdata = dma_gnt_s ? dma_wdata : (cpu_gnt_s ? cpu_wdata : {DATA_WIDTH{1'b0}});

    assign cpu_rvalid = rd_pend_r & (rd_owner_r == OWN_CPU);
    assign dma_rvalid = rd_pend_r & (rd_owner_r == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};
    assign dma_rdata  = dma_rvalid ? mem_rdata : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_dmem_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_W(AW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read DMEM driven by the arbiter's command.
    bit [DW-1:0] dmem [256];
    always @(posedge clk) begin
        if (mem_read) mem_rdata <= dmem[mem_addr];
        if (mem_write) dmem[mem_addr] <= mem_wdata;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model state
    bit          m_lock, m_cpu_first, m_rel, m_cg, m_dg;
    int          m_wait, m_beats;
    bit [DW-1:0] ref_mem [256];
    typedef struct { bit own_dma; logic [DW-1:0] data; int cyc; } rsp_t;
    rsp_t        rq[$];

    int vectors = 0;
    int errors = 0;
    logic [1:0] last_g, last_rv;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0; m_cpu_first = 1'b0; m_rel = 1'b0; m_wait = 0; m_beats = 0;
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit lk);
        dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d; dma_lock = lk;
    endtask

    // One cycle: predict grants, compare the command, then advance the model at the clock edge.
    task automatic step(input bit rst_after = 1'b0);
        bit dma_first, forced, er, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #1;
        if (m_lock) begin
            m_dg = dma_req; m_cg = 1'b0;
        end else begin
            dma_first = (m_wait >= MAX_WAIT || m_rel) && !m_cpu_first;
            m_dg = dma_req && (dma_first || !cpu_req);
            m_cg = cpu_req && !m_dg;
        end
        er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        if (m_dg) begin
            ea = dma_addr; ed = dma_wdata; er = !dma_we; ew = dma_we;
            if (dma_we) ref_mem[dma_addr] = dma_wdata;
            else rq.push_back('{1'b1, ref_mem[dma_addr], cyc_cnt});
        end else if (m_cg) begin
            ea = cpu_addr; ed = cpu_wdata; er = !cpu_we; ew = cpu_we;
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            else rq.push_back('{1'b0, ref_mem[cpu_addr], cyc_cnt});
        end
        chk("cmd", 64'({cpu_gnt, dma_gnt, cpu_stall, mem_read, mem_write, mem_addr, mem_wdata}),
                   64'({m_cg, m_dg, cpu_req && !m_cg, er, ew, ea, ed}));
        last_g  = {cpu_gnt, dma_gnt};
        last_rv = {cpu_rvalid, dma_rvalid};
        @(posedge clk);
        if (rst_after) begin
            #1;
            reset = 1'b0;
            rq.delete();
            model_reset();
        end else begin
            forced = m_dg && dma_lock && (m_beats + 1 == LOCK_MAX);
            if (m_dg && dma_lock && !forced) begin m_lock = 1'b1; m_beats++; end
            else begin m_lock = 1'b0; m_beats = 0; end
            if (dma_req && !m_dg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else m_wait = 0;
            if (forced) m_cpu_first = 1'b1;
            else if (m_cg || !cpu_req) m_cpu_first = 1'b0;
            if (forced) m_rel = 1'b1;
            else if (m_dg || !dma_req) m_rel = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Response monitor: pops the scoreboard whenever a read response is due or appears.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rq.size() > 0 && rq[0].cyc == cyc_cnt - 1) begin
                e = rq.pop_front();
                chk("rsp", 64'({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata}),
                    e.own_dma ? 64'({2'b01, 16'h0000, e.data}) : 64'({2'b10, e.data, 16'h0000}));
            end else if (cpu_rvalid || dma_rvalid) begin
                chk("spurious_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'(2'b00));
            end
        end
    end

    logic [1:0] t2_exp [6]  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    logic [1:0] t3_exp [13] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

    initial begin
        int bi;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rsp", 64'({cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata}), 64'h0);
        chk("rst_cmd", 64'({cpu_gnt, dma_gnt, cpu_stall, mem_read, mem_write, mem_addr, mem_wdata}), 64'h0);
        reset = 1'b1;

        // CPU read of a preloaded word
        set_dma(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0); step();
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        set_cpu(1'b1, 1'b0, 8'h10, '0); step();
        chk("t1_gnt", 64'(last_g), 64'(2'b10));
        set_cpu(1'b0, 1'b0, '0, '0); step();
        chk("t1_rv", 64'(last_rv), 64'(2'b10));

        // Continuous contention: DMA wins once every MAX_WAIT+1 cycles
        idle(2);
        set_cpu(1'b1, 1'b0, 8'h10, '0);
        set_dma(1'b1, 1'b0, 8'h11, '0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t2_gnt", 64'(last_g), 64'(t2_exp[k]));
        end

        // Locked burst cut at LOCK_MAX beats, one CPU slot, then DMA resumes
        idle(2);
        bi = 0;
        set_dma(1'b1, 1'b1, 8'h20, 16'hD000, 1'b1);
        for (int k = 0; k < 13; k++) begin
            step();
            chk("t3_gnt", 64'(last_g), 64'(t3_exp[k]));
            if (m_dg) bi++;
            if (bi < 11) set_dma(1'b1, 1'b1, AW'(8'h20 + bi), DW'(16'hD000 + bi), bi < 10);
            else set_dma(1'b0, 1'b0, '0, '0, 1'b0);
            set_cpu(1'b1, 1'b0, 8'h30, '0);
        end
        idle(2);

        // Read routing: DMA read then CPU read back-to-back
        set_dma(1'b1, 1'b1, 8'h05, 16'h1234, 1'b0); step();
        set_dma(1'b1, 1'b1, 8'h06, 16'h5678, 1'b0); step();
        set_dma(1'b1, 1'b0, 8'h05, '0, 1'b0); step();
        set_dma(1'b0, 1'b0, '0, '0, 1'b0);
        set_cpu(1'b1, 1'b0, 8'h06, '0); step();
        chk("t4_dma_rv", 64'(last_rv), 64'(2'b01));
        set_cpu(1'b0, 1'b0, '0, '0); step();
        chk("t4_cpu_rv", 64'(last_rv), 64'(2'b10));

        // CPU read response overlapping a DMA write
        set_cpu(1'b1, 1'b0, 8'h10, '0); step();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dma(1'b1, 1'b1, 8'h41, 16'h7E7E, 1'b0); step();
        chk("t6_overlap", 64'({last_rv, last_g}), 64'(4'b1001));
        chk("t6_mem", 64'(dmem[8'h41]), 64'(16'h7E7E));

        // Reset during beat 3 of a lock with a read in flight
        idle(2);
        set_dma(1'b1, 1'b1, 8'h50, 16'hAAAA, 1'b1); step();
        set_dma(1'b1, 1'b1, 8'h51, 16'hBBBB, 1'b1);
        set_cpu(1'b1, 1'b0, 8'h10, '0); step();
        set_dma(1'b1, 1'b0, 8'h50, '0, 1'b1); step(1'b1);
        chk("t5_rv_dropped", 64'({cpu_rvalid, dma_rvalid}), 64'(2'b00));
        @(negedge clk);
        chk("t5_rv_held", 64'({cpu_rvalid, dma_rvalid}), 64'(2'b00));
        reset = 1'b1;
        set_dma(1'b1, 1'b0, 8'h50, '0, 1'b0); step();
        chk("t5_cpu_first", 64'(last_g), 64'(2'b10));
        idle(3);

        // Random traffic, requesters hold until granted
        for (int n = 0; n < 600; n++) begin
            step();
            if (!cpu_req || m_cg)
                set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), DW'($urandom));
            else if ($urandom_range(0, 7) == 0) cpu_addr = AW'($urandom_range(0, 15));
            if (!dma_req || m_dg)
                set_dma($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 7) == 0) dma_wdata = DW'($urandom);
        end
        idle(3);
        chk("drain", 64'(rq.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
